tlb: RTL and testbench

Joint TLB for the MIPS32 core: 16 fully-associative dual-page entries, two lookup ports, one write port and one read port. Sits beside `cp0`. It answers instruction fetch translation on search port 0, and data translation plus `tlbp` on search port 1. It accepts `tlbwi` writes built from EntryHi/EntryLo0/EntryLo1/Index and returns entry contents for `tlbr`.

---
 rtl/tlb_pkg.sv | 45 ++++
 rtl/tlb_match.sv | 15 +
 rtl/tlb.sv | 155 +++++++++++++++
 tb/tb_tlb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: geometry, field widths, the packed entry layout and the page view.
package tlb_pkg;

    localparam int TLBNUM    = 16;
    localparam int TLB_IDX_W = 4;
    localparam int VPN2_W    = 19;
    localparam int PFN_W     = 20;
    localparam int ASID_W    = 8;

    // Bit offsets of each field in the packed entry, LSB first.
    localparam int OFF_V1   = 0;
    localparam int OFF_D1   = 1;
    localparam int OFF_C1   = 2;
    localparam int OFF_PFN1 = 5;
    localparam int OFF_V0   = 25;
    localparam int OFF_D0   = 26;
    localparam int OFF_C0   = 27;
    localparam int OFF_PFN0 = 30;
    localparam int OFF_G    = 50;
    localparam int OFF_ASID = 51;
    localparam int OFF_VPN2 = 59;
    localparam int ENTRY_W  = 78;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } tlb_page_t;

endpackage

// File: rtl/tlb_match.sv
// Single-entry lookup comparator: VPN2 must match, and ASID must match unless the entry is global.
module tlb_match
    import tlb_pkg::*;
(
    input  logic [VPN2_W-1:0] i_ent_vpn2,
    input  logic [ASID_W-1:0] i_ent_asid,
    input  logic              i_ent_g,
    input  logic [VPN2_W-1:0] i_key_vpn2,
    input  logic [ASID_W-1:0] i_key_asid,
    output logic              o_hit
);

    assign o_hit = (i_ent_vpn2 == i_key_vpn2) && (i_ent_g || (i_ent_asid == i_key_asid));

endmodule

// File: rtl/tlb.sv
// Joint 16-entry dual-page TLB: two combinational search ports, one write port, one read port.
module tlb
    import tlb_pkg::*;
#(
    parameter int TLB_N = TLBNUM
)
(
    input  logic                 clk,
    input  logic                 resetn,

    input  logic [VPN2_W-1:0]    s0_vpn2,
    input  logic                 s0_odd_page,
    input  logic [ASID_W-1:0]    s0_asid,
    output logic                 s0_found,
    output logic [TLB_IDX_W-1:0] s0_index,
    output logic [PFN_W-1:0]     s0_pfn,
    output logic [2:0]           s0_c,
    output logic                 s0_d,
    output logic                 s0_v,

    input  logic [VPN2_W-1:0]    s1_vpn2,
    input  logic                 s1_odd_page,
    input  logic [ASID_W-1:0]    s1_asid,
    output logic                 s1_found,
    output logic [TLB_IDX_W-1:0] s1_index,
    output logic [PFN_W-1:0]     s1_pfn,
    output logic [2:0]           s1_c,
    output logic                 s1_d,
    output logic                 s1_v,

    input  logic                 we,
    input  logic [TLB_IDX_W-1:0] w_index,
    input  logic [VPN2_W-1:0]    w_vpn2,
    input  logic [ASID_W-1:0]    w_asid,
    input  logic                 w_g,
    input  logic [PFN_W-1:0]     w_pfn0,
    input  logic [2:0]           w_c0,
    input  logic                 w_d0,
    input  logic                 w_v0,
    input  logic [PFN_W-1:0]     w_pfn1,
    input  logic [2:0]           w_c1,
    input  logic                 w_d1,
    input  logic                 w_v1,

    input  logic [TLB_IDX_W-1:0] r_index,
    output logic [VPN2_W-1:0]    r_vpn2,
    output logic [ASID_W-1:0]    r_asid,
    output logic                 r_g,
    output logic [PFN_W-1:0]     r_pfn0,
    output logic [2:0]           r_c0,
    output logic                 r_d0,
    output logic                 r_v0,
    output logic [PFN_W-1:0]     r_pfn1,
    output logic [2:0]           r_c1,
    output logic                 r_d1,
    output logic                 r_v1
);

    tlb_entry_t r_entries [TLB_N];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_N; i++) begin
                r_entries[i] <= '0;
            end
        end else if (we) begin
            r_entries[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                   pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                   pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
        end
    end

    logic [VPN2_W-1:0]    w_key_vpn2 [2];
    logic [ASID_W-1:0]    w_key_asid [2];
    logic                 w_key_odd  [2];
    logic [TLB_N-1:0]     w_hit      [2];
    logic [1:0]           w_found;
    logic [TLB_IDX_W-1:0] w_idx      [2];
    tlb_page_t            w_page     [2];

    assign w_key_vpn2[0] = s0_vpn2;
    assign w_key_vpn2[1] = s1_vpn2;
    assign w_key_asid[0] = s0_asid;
    assign w_key_asid[1] = s1_asid;
    assign w_key_odd[0]  = s0_odd_page;
    assign w_key_odd[1]  = s1_odd_page;

    for (genvar p = 0; p < 2; p++) begin : g_port
        for (genvar e = 0; e < TLB_N; e++) begin : g_ent
            tlb_match u_match (
                .i_ent_vpn2 (r_entries[e].vpn2),
                .i_ent_asid (r_entries[e].asid),
                .i_ent_g    (r_entries[e].g),
                .i_key_vpn2 (w_key_vpn2[p]),
                .i_key_asid (w_key_asid[p]),
                .o_hit      (w_hit[p][e])
            );
        end

        logic                 w_f;
        logic [TLB_IDX_W-1:0] w_i;
        tlb_entry_t           w_e;
        tlb_page_t            w_pg;

        // Scan from the top down so the lowest matching index is the one left standing.
        always_comb begin
            w_f = 1'b0;
            w_i = '0;
            w_e = '0;
            for (int i = TLB_N - 1; i >= 0; i--) begin
                if (w_hit[p][i]) begin
                    w_f = 1'b1;
                    w_i = TLB_IDX_W'(i);
                    w_e = r_entries[i];
                end
            end
            w_pg = '0;
            if (w_f) begin
                w_pg = w_key_odd[p] ? '{pfn: w_e.pfn1, c: w_e.c1, d: w_e.d1, v: w_e.v1}
                                    : '{pfn: w_e.pfn0, c: w_e.c0, d: w_e.d0, v: w_e.v0};
            end
        end

        assign w_found[p] = w_f;
        assign w_idx[p]   = w_i;
        assign w_page[p]  = w_pg;
    end

    assign s0_found = w_found[0];
    assign s0_index = w_idx[0];
    assign s0_pfn   = w_page[0].pfn;
    assign s0_c     = w_page[0].c;
    assign s0_d     = w_page[0].d;
    assign s0_v     = w_page[0].v;

    assign s1_found = w_found[1];
    assign s1_index = w_idx[1];
    assign s1_pfn   = w_page[1].pfn;
    assign s1_c     = w_page[1].c;
    assign s1_d     = w_page[1].d;
    assign s1_v     = w_page[1].v;

    assign r_vpn2 = r_entries[r_index].vpn2;
    assign r_asid = r_entries[r_index].asid;
    assign r_g    = r_entries[r_index].g;
    assign r_pfn0 = r_entries[r_index].pfn0;
    assign r_c0   = r_entries[r_index].c0;
    assign r_d0   = r_entries[r_index].d0;
    assign r_v0   = r_entries[r_index].v0;
    assign r_pfn1 = r_entries[r_index].pfn1;
    assign r_c1   = r_entries[r_index].c1;
    assign r_d1   = r_entries[r_index].d1;
    assign r_v1   = r_entries[r_index].v1;

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: stimulus pushes expected outputs into a queue, a negedge monitor compares.
module tb_tlb;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0;
    logic        s0_odd_page = 1'b0, s1_odd_page = 1'b0;
    logic [7:0]  s0_asid = '0, s1_asid = '0;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s0_v, s1_d, s1_v;

    logic        we = 1'b0;
    logic [3:0]  w_index = '0;
    logic [18:0] w_vpn2 = '0;
    logic [7:0]  w_asid = '0;
    logic        w_g = 1'b0;
    logic [19:0] w_pfn0 = '0, w_pfn1 = '0;
    logic [2:0]  w_c0 = '0, w_c1 = '0;
    logic        w_d0 = 1'b0, w_v0 = 1'b0, w_d1 = 1'b0, w_v1 = 1'b0;

    logic [3:0]  r_index = '0;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;

    tlb dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard state
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:  return 32'(s0_found);
            1:  return 32'(s0_index);
            2:  return 32'(s0_pfn);
            3:  return 32'(s0_c);
            4:  return 32'(s0_d);
            5:  return 32'(s0_v);
            10: return 32'(s1_found);
            11: return 32'(s1_index);
            12: return 32'(s1_pfn);
            13: return 32'(s1_c);
            14: return 32'(s1_d);
            15: return 32'(s1_v);
            20: return 32'(r_vpn2);
            21: return 32'(r_asid);
            22: return 32'(r_g);
            23: return 32'(r_pfn0);
            24: return 32'(r_c0);
            25: return 32'(r_d0);
            26: return 32'(r_v0);
            27: return 32'(r_pfn1);
            28: return 32'(r_c1);
            29: return 32'(r_d1);
            30: return 32'(r_v1);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_q.push_back(val);
        sel_q.push_back(sel);
        name_q.push_back(tag);
    endtask

    // Expected search result on port p (0/1); a miss is expressed as found=0 with all zeros.
    task automatic expect_s(input string tag, input int p, input logic f, input logic [3:0] idx,
                            input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v);
        int b = p * 10;
        push({tag, ".found"}, b + 0, 32'(f));
        push({tag, ".index"}, b + 1, 32'(idx));
        push({tag, ".pfn"},   b + 2, 32'(pfn));
        push({tag, ".c"},     b + 3, 32'(c));
        push({tag, ".d"},     b + 4, 32'(d));
        push({tag, ".v"},     b + 5, 32'(v));
    endtask

    task automatic expect_r(input string tag, input logic [18:0] vpn2, input logic [7:0] asid,
                            input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                            input logic d0, input logic v0, input logic [19:0] pfn1,
                            input logic [2:0] c1, input logic d1, input logic v1);
        push({tag, ".vpn2"}, 20, 32'(vpn2));
        push({tag, ".asid"}, 21, 32'(asid));
        push({tag, ".g"},    22, 32'(g));
        push({tag, ".pfn0"}, 23, 32'(pfn0));
        push({tag, ".c0"},   24, 32'(c0));
        push({tag, ".d0"},   25, 32'(d0));
        push({tag, ".v0"},   26, 32'(v0));
        push({tag, ".pfn1"}, 27, 32'(pfn1));
        push({tag, ".c1"},   28, 32'(c1));
        push({tag, ".d1"},   29, 32'(d1));
        push({tag, ".v1"},   30, 32'(v1));
    endtask

    // Monitor: outputs are combinational, so everything queued this cycle is checked at negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            logic [31:0] a;
            int          s;
            string       n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            a = actual(s);
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                         input logic d0, input logic v0, input logic [19:0] pfn1,
                         input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic search(input int p, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        if (p == 0) begin
            s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
        end else begin
            s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
        end
    endtask

    initial begin
        #12 resetn = 1'b1;
        tick();

        // Reset state
        r_index = 4'd7;
        expect_r("rst_read7", '0, '0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        search(0, 19'h0, 1'b0, 8'h00);
        expect_s("rst_s0_zero", 0, 1, 4'd0, '0, '0, 0, 0);
        search(1, 19'h12345, 1'b1, 8'h05);
        expect_s("rst_s1_miss", 1, 0, 4'd0, '0, '0, 0, 0);
        tick();

        // Write entry 3; no bypass in the write cycle
        set_w(4'd3, 19'h12345, 8'h05, 0, 20'h00ABC, 3'd0, 0, 1, 20'h00DEF, 3'd0, 1, 1);
        expect_s("w3_cycle_miss", 1, 0, 4'd0, '0, '0, 0, 0);
        tick();
        we = 1'b0;
        expect_s("e3_odd", 1, 1, 4'd3, 20'h00DEF, 3'd0, 1, 1);
        search(0, 19'h12345, 1'b0, 8'h05);
        expect_s("e3_even", 0, 1, 4'd3, 20'h00ABC, 3'd0, 0, 1);
        r_index = 4'd3;
        expect_r("read3", 19'h12345, 8'h05, 0, 20'h00ABC, 3'd0, 0, 1, 20'h00DEF, 3'd0, 1, 1);
        tick();
        search(1, 19'h12345, 1'b1, 8'h06);
        expect_s("e3_asid_miss", 1, 0, 4'd0, '0, '0, 0, 0);
        tick();

        // Rewrite entry 3 as global
        set_w(4'd3, 19'h12345, 8'h05, 1, 20'h00ABC, 3'd0, 0, 1, 20'h00DEF, 3'd0, 1, 1);
        expect_s("g_wcycle_miss", 1, 0, 4'd0, '0, '0, 0, 0);
        tick();
        we = 1'b0;
        expect_s("g_hit", 1, 1, 4'd3, 20'h00DEF, 3'd0, 1, 1);
        tick();

        // Duplicate global entries 9 and 2: lowest index wins
        set_w(4'd9, 19'h00400, 8'h11, 1, 20'h11111, 3'd3, 0, 1, 20'h19999, 3'd1, 1, 1);
        tick();
        set_w(4'd2, 19'h00400, 8'h33, 1, 20'h22222, 3'd5, 1, 1, 20'h0, 3'd0, 0, 0);
        tick();
        we = 1'b0;
        search(0, 19'h00400, 1'b0, 8'h77);
        expect_s("dup_even", 0, 1, 4'd2, 20'h22222, 3'd5, 1, 1);
        search(1, 19'h00400, 1'b1, 8'h01);
        expect_s("dup_odd_invalid", 1, 1, 4'd2, 20'h0, 3'd0, 0, 0);
        tick();

        // Independent ports: s0 on entry 4 while it is rewritten, s1 on entry 12
        set_w(4'd4, 19'h0AAAA, 8'h01, 0, 20'h44444, 3'd1, 0, 1, 20'h0, 3'd0, 0, 0);
        tick();
        set_w(4'd12, 19'h0CCCC, 8'h01, 0, 20'h0, 3'd0, 0, 0, 20'hCCCCC, 3'd4, 1, 1);
        tick();
        set_w(4'd4, 19'h0AAAA, 8'h01, 0, 20'h55555, 3'd2, 1, 1, 20'h0, 3'd0, 0, 0);
        search(0, 19'h0AAAA, 1'b0, 8'h01);
        search(1, 19'h0CCCC, 1'b1, 8'h01);
        expect_s("e4_old", 0, 1, 4'd4, 20'h44444, 3'd1, 0, 1);
        expect_s("e12_wcycle", 1, 1, 4'd12, 20'hCCCCC, 3'd4, 1, 1);
        tick();
        we = 1'b0;
        expect_s("e4_new", 0, 1, 4'd4, 20'h55555, 3'd2, 1, 1);
        expect_s("e12_after", 1, 1, 4'd12, 20'hCCCCC, 3'd4, 1, 1);
        tick();

        // Back-to-back writes to one entry: last write wins
        set_w(4'd5, 19'h00055, 8'h02, 0, 20'h00001, 3'd0, 0, 1, 20'h0, 3'd0, 0, 0);
        tick();
        set_w(4'd5, 19'h00055, 8'h02, 0, 20'h00002, 3'd0, 0, 1, 20'h0, 3'd0, 0, 0);
        tick();
        we = 1'b0;
        r_index = 4'd5;
        expect_r("rewrite5", 19'h00055, 8'h02, 0, 20'h00002, 3'd0, 0, 1, 20'h0, 3'd0, 0, 0);
        tick();

        // Asynchronous reset mid-cycle, checked before the next clock edge
        r_index = 4'd12;
        #1 resetn = 1'b0;
        expect_r("async_rst_read12", '0, '0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        expect_s("async_rst_s1", 1, 0, 4'd0, '0, '0, 0, 0);
        search(0, 19'h0, 1'b0, 8'h00);
        expect_s("async_rst_s0", 0, 1, 4'd0, '0, '0, 0, 0);
        set_w(4'd6, 19'h00066, 8'h06, 1, 20'h66666, 3'd6, 1, 1, 20'h66666, 3'd6, 1, 1);
        tick();
        r_index = 4'd6;
        expect_r("rst_beats_we", '0, '0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
        tick();
        we = 1'b0;
        resetn = 1'b1;
        tick();
        tick();

        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish within 20000 time units");
        $fatal(1);
    end

endmodule
